// File: rtl/seq_addsub.sv
// seq_addsub -- multi-cycle adder/subtractor.
//
// Works through the WIDTH-bit operands CHUNK bits per clock, LSB first. The
// carry between chunks is held in a register. A start/busy/done handshake
// frames each operation. An operation takes N = WIDTH/CHUNK processing
// cycles plus one DONE cycle.
//
// Parameters:
//   WIDTH    operand/result width (>= 2)
//   CHUNK    bits processed per clock (must divide WIDTH)
//
// Ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   start     request an operation (sampled in IDLE or DONE only)
//   sub       0: a + b + cin, 1: a - b (cin ignored)
//   a, b      operands, latched on the accepted start
//   cin       carry-in for add, latched on the accepted start
//   busy      high while the operation is running
//   done      one-cycle pulse when sum/cout/overflow become valid
//   sum       result, held until the next accepted start
//   cout      carry out of the MSB (sub: 1 = no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
//   zero      (only with SEQ_ADDSUB_ZERO_FLAG_EN) result was all zeros
//
// Optional feature macro: SEQ_ADDSUB_ZERO_FLAG_EN adds the zero output.

module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
  logic               zero_q, zero_d;
`endif

  // Chunk adder: low CHUNK bits of A and B plus the running carry.
  logic [CHUNK:0]       chunk_add_s;
  logic [CHUNK-1:0]     chunk_sum_s;
  logic                 chunk_cout_s;
  logic                 msb_cin_s;
  logic [WIDTH+CHUNK-1:0] sum_shift_s;

  assign chunk_add_s  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, carry_q};
  assign chunk_sum_s  = chunk_add_s[CHUNK-1:0];
  assign chunk_cout_s = chunk_add_s[CHUNK];
  // Carry into the top bit of this chunk, recovered from that bit's sum.
  // Only meaningful on the final chunk, where it is the carry into the MSB.
  assign msb_cin_s    = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum_s[CHUNK-1];
  // Concatenate then slice so CHUNK == WIDTH needs no zero-width part-select.
  assign sum_shift_s  = {chunk_sum_s, sum_q};

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          // Subtract as a + ~b + 1.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = sum_shift_s[WIDTH+CHUNK-1:CHUNK];
        carry_d = chunk_cout_s;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(N - 1)) begin
          cout_d  = chunk_cout_s;
          ovf_d   = msb_cin_s ^ chunk_cout_s;
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
          zero_d  = (sum_shift_s[WIDTH+CHUNK-1:CHUNK] == {WIDTH{1'b0}});
`endif
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
  assign zero     = zero_q;
`endif

endmodule

// File: tb/tb_seq_addsub.sv
// Directed testbench for seq_addsub: one 8-bit instance with CHUNK=1 and one
// with CHUNK=4. Inputs are driven and outputs sampled on the falling edge.

module tb_seq_addsub;

  logic       clk;
  logic       rst_n;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;

  logic       start8, busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       start4, busy4, done4, cout4, ovf4;
  logic [7:0] sum4;
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
  logic       zero8, zero4;
`endif

  int n_checks;
  int n_fail;

  seq_addsub #(.WIDTH(8), .CHUNK(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub), .a(a), .b(b),
    .cin(cin), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
    .zero(zero8),
`endif
    .overflow(ovf8)
  );

  seq_addsub #(.WIDTH(8), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub), .a(a), .b(b),
    .cin(cin), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
    .zero(zero4),
`endif
    .overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start on the 8-bit instance; returns at the falling edge after
  // the accepting rising edge.
  task automatic issue_start8(input logic [7:0] av, input logic [7:0] bv,
                              input logic s, input logic c);
    a = av; b = bv; sub = s; cin = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    // Scramble inputs to show they are latched.
    a = 8'hA5; b = 8'h5A; sub = ~s; cin = ~c;
  endtask

  // Count busy cycles until done (bounded).
  task automatic wait_done8(output int busy_cnt);
    int cyc;
    busy_cnt = 0;
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 20) begin
      if (busy8 === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    n_checks++;
    if ({busy4, done4, sum4, cout4, ovf4} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset4: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy4, done4, sum4, cout4, ovf4);
    end
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
    n_checks++;
    if (zero8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_zero: got %b, required 0", zero8);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_overflow;
    int bc;
    issue_start8(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_done8(bc);
    n_checks++;
    if (done8 !== 1'b1) begin
      n_fail++;
      $display("FAIL add_done: got %b, required 1", done8);
    end
    n_checks++;
    if (bc != 8) begin
      n_fail++;
      $display("FAIL add_busy_cycles: got %0d, required 8", bc);
    end
    n_checks++;
    if ({sum8, cout8, ovf8} !== {8'h96, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL add_result: sum=%h cout=%b ovf=%b, required 96 0 1",
               sum8, cout8, ovf8);
    end
    @(negedge clk);
    n_checks++;
    if ({done8, busy8, sum8} !== {1'b0, 1'b0, 8'h96}) begin
      n_fail++;
      $display("FAIL add_after: done=%b busy=%b sum=%h, required 0 0 96",
               done8, busy8, sum8);
    end
  endtask

  task automatic test_carry_back_to_back;
    int bc;
    issue_start8(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done8(bc);
    n_checks++;
    if ({done8, sum8, cout8, ovf8} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_result: done=%b sum=%h cout=%b ovf=%b, required 1 00 1 0",
               done8, sum8, cout8, ovf8);
    end
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
    n_checks++;
    if (zero8 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_zero: got %b, required 1", zero8);
    end
`endif
    // Second start held during the DONE cycle.
    issue_start8(8'h10, 8'h20, 1'b1, 1'b0);
    n_checks++;
    if ({busy8, done8} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy8, done8);
    end
    wait_done8(bc);
    n_checks++;
    if (bc != 8 || done8 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_latency: busy cycles=%0d done=%b, required 8 1", bc, done8);
    end
    n_checks++;
    if ({sum8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_result: sum=%h cout=%b ovf=%b, required f0 0 0",
               sum8, cout8, ovf8);
    end
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
    n_checks++;
    if (zero8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_zero: got %b, required 0", zero8);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_sub_overflow;
    int bc;
    issue_start8(8'h80, 8'h01, 1'b1, 1'b1);
    wait_done8(bc);
    n_checks++;
    if ({done8, sum8, cout8, ovf8} !== {1'b1, 8'h7F, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_result: done=%b sum=%h cout=%b ovf=%b, required 1 7f 1 1",
               done8, sum8, cout8, ovf8);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int dones;
    issue_start8(8'h5A, 8'h3C, 1'b0, 1'b0);   // accepted at edge k
    @(negedge clk);                             // after k+1
    @(negedge clk);                             // after k+2
    rst_n = 1'b0;
    @(negedge clk);                             // after k+3
    n_checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      n_fail++;
      $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL midrun_no_done: %0d active cycles seen, required 0", dones);
    end
  endtask

  task automatic test_chunk4;
    a = 8'hFF; b = 8'hFF; sub = 1'b0; cin = 1'b1; start4 = 1'b1;
    @(negedge clk);                             // after edge k
    n_checks++;
    if ({busy4, done4} !== 2'b10) begin
      n_fail++;
      $display("FAIL c4_busy: busy=%b done=%b, required 1 0", busy4, done4);
    end
    // start still high across edge k+1 while running: must be ignored.
    a = 8'h00; b = 8'h00; cin = 1'b0;
    @(negedge clk);                             // after edge k+1
    start4 = 1'b0;
    n_checks++;
    if ({busy4, done4} !== 2'b10) begin
      n_fail++;
      $display("FAIL c4_run: busy=%b done=%b, required 1 0", busy4, done4);
    end
    @(negedge clk);                             // after edge k+2
    n_checks++;
    if ({done4, sum4, cout4, ovf4} !== {1'b1, 8'hFF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL c4_result: done=%b sum=%h cout=%b ovf=%b, required 1 ff 1 0",
               done4, sum4, cout4, ovf4);
    end
    @(negedge clk);
    n_checks++;
    if ({busy4, done4, sum4} !== {1'b0, 1'b0, 8'hFF}) begin
      n_fail++;
      $display("FAIL c4_ignored_start: busy=%b done=%b sum=%h, required 0 0 ff",
               busy4, done4, sum4);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n  = 1'b0;
    start8 = 1'b0;
    start4 = 1'b0;
    sub    = 1'b0;
    a      = 8'h00;
    b      = 8'h00;
    cin    = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_overflow();
    test_carry_back_to_back();
    test_sub_overflow();
    test_reset_mid_run();
    test_chunk4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
